// File: rtl/axil_mst_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axil_mst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } axil_mst_state_e;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam logic [1:0]  RESP_DECERR   = 2'b11;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/axil_mst_watchdog.sv
// Outstanding-transaction watchdog: counts enabled cycles, pulses expire on
// the last allowed cycle. Only instantiated when AXIL_MST_TIMEOUT_EN is set.
module axil_mst_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_main_a0,
    input  logic rst_main,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count;

    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 16'd1;
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a command/response stream.
// Define AXIL_MST_TIMEOUT_EN to add the outstanding-transaction watchdog.
module axil_cmd_master
    import axil_mst_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic            clk_main_a0,
    input  logic            rst_main,
    // Handshakes: a beat transfers on the rising edge where valid && ready;
    // a valid, once raised, holds with stable payload until that edge.
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [31:0]     cmd_addr,
    input  logic [31:0]     cmd_wdata,
    input  logic [3:0]      cmd_wstrb,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_write,
    output logic [31:0]     rsp_rdata,
    output logic [1:0]      rsp_resp,
    output logic            rsp_timeout,
    output logic [31:0]     m_awaddr,
    output logic            m_awvalid,
    input  logic            m_awready,
    output logic [31:0]     m_wdata,
    output logic [3:0]      m_wstrb,
    output logic            m_wvalid,
    input  logic            m_wready,
    input  logic [1:0]      m_bresp,
    input  logic            m_bvalid,
    output logic            m_bready,
    output logic [31:0]     m_araddr,
    output logic            m_arvalid,
    input  logic            m_arready,
    input  logic [31:0]     m_rdata,
    input  logic [1:0]      m_rresp,
    input  logic            m_rvalid,
    output logic            m_rready,
    output logic [15:0]     err_cnt,
    output axil_mst_state_e dbg_state
);
    axil_mst_state_e state;
    logic            wd_expire;
    logic            enter_rsp;
    logic [1:0]      nxt_resp;
    logic [31:0]     nxt_rdata;
    logic            nxt_timeout;
    logic            aw_ok;
    logic            w_ok;

    assign dbg_state = state;

    // A dropped valid inside WR means that channel was already accepted.
    assign aw_ok = !m_awvalid || m_awready;
    assign w_ok  = !m_wvalid  || m_wready;

`ifdef AXIL_MST_TIMEOUT_EN
    axil_mst_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_main_a0(clk_main_a0),
        .rst_main   (rst_main),
        .clear      ((state == ST_IDLE) || (state == ST_RSP)),
        .enable     ((state != ST_IDLE) && (state != ST_RSP)),
        .expire     (wd_expire)
    );
`else
    // No watchdog: the legal range of TIMEOUT_CYCLES makes this constant 0.
    assign wd_expire = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        enter_rsp   = 1'b0;
        nxt_resp    = RESP_OKAY;
        nxt_rdata   = '0;
        nxt_timeout = 1'b0;
        if (wd_expire) begin
            enter_rsp   = 1'b1;
            nxt_resp    = RESP_SLVERR;
            nxt_rdata   = TIMEOUT_RDATA;
            nxt_timeout = 1'b1;
        end else if ((state == ST_WR_RESP) && m_bvalid) begin
            enter_rsp = 1'b1;
            nxt_resp  = m_bresp;
        end else if ((state == ST_RD_DATA) && m_rvalid) begin
            enter_rsp = 1'b1;
            nxt_resp  = m_rresp;
            nxt_rdata = m_rdata;
        end
    end

    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_timeout <= 1'b0;
            m_awaddr    <= '0;
            m_awvalid   <= 1'b0;
            m_wdata     <= '0;
            m_wstrb     <= '0;
            m_wvalid    <= 1'b0;
            m_bready    <= 1'b0;
            m_araddr    <= '0;
            m_arvalid   <= 1'b0;
            m_rready    <= 1'b0;
            err_cnt     <= '0;
        end else if (enter_rsp) begin
            // Normal completion or watchdog abort: every channel drops at once.
            m_awvalid   <= 1'b0;
            m_wvalid    <= 1'b0;
            m_arvalid   <= 1'b0;
            m_bready    <= 1'b0;
            m_rready    <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_write   <= (state == ST_WR) || (state == ST_WR_RESP);
            rsp_rdata   <= nxt_rdata;
            rsp_resp    <= nxt_resp;
            rsp_timeout <= nxt_timeout;
            if (nxt_timeout || (nxt_resp != RESP_OKAY)) begin
                err_cnt <= sat_inc16(err_cnt);
            end
            state <= ST_RSP;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            m_awaddr  <= cmd_addr;
                            m_wdata   <= cmd_wdata;
                            m_wstrb   <= cmd_wstrb;
                            m_awvalid <= 1'b1;
                            m_wvalid  <= 1'b1;
                            state     <= ST_WR;
                        end else begin
                            m_araddr  <= cmd_addr;
                            m_arvalid <= 1'b1;
                            state     <= ST_RD_ADDR;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_WR: begin
                    if (m_awvalid && m_awready) m_awvalid <= 1'b0;
                    if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
                    if (aw_ok && w_ok) begin
                        m_bready <= 1'b1;
                        state    <= ST_WR_RESP;
                    end
                end
                ST_RD_ADDR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state     <= ST_RD_DATA;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a register-model AXI-L slave.
// Define AXIL_MST_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_axil_cmd_master;
    import axil_mst_pkg::*;

    logic            clk_main_a0 = 1'b0;
    logic            rst_main;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [31:0]     cmd_addr, cmd_wdata;
    logic [3:0]      cmd_wstrb;
    logic            rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [31:0]     rsp_rdata;
    logic [1:0]      rsp_resp;
    logic [31:0]     m_awaddr, m_wdata, m_araddr, m_rdata;
    logic            m_awvalid, m_awready, m_wvalid, m_wready;
    logic [3:0]      m_wstrb;
    logic [1:0]      m_bresp, m_rresp;
    logic            m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
    logic [15:0]     err_cnt;
    axil_mst_state_e dbg_state;

    int checks = 0;
    int failures = 0;

    // slave knobs, owned by the stimulus block
    int         w_delay = 0;
    bit         b_block = 0;
    bit         ar_block = 0;
    logic [1:0] bresp_val = 2'b00;
    logic [1:0] rresp_val = 2'b00;

    // slave state, owned by the slave block
    logic [31:0] mem [0:255];
    bit          aw_got, w_got, ar_got;
    logic [31:0] aw_a, w_d, ar_a;
    logic [3:0]  w_s;
    int          w_wait;
    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    bit          p_awv, p_wv, p_arv, p_br, p_rr;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;

    always #5 clk_main_a0 = ~clk_main_a0;

    axil_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk_main_a0(clk_main_a0), .rst_main(rst_main),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .err_cnt(err_cnt), .dbg_state(dbg_state)
    );

    // Register-model slave. Runs on the falling edge; p_* hold the master
    // outputs that were present at the rising edge just passed.
    always @(negedge clk_main_a0) begin
        if (rst_main) begin
            for (int i = 0; i < 256; i++) mem[i] = 32'h0;
            aw_got = 0; w_got = 0; ar_got = 0; w_wait = 0;
            m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
            m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
            p_awv = 0; p_wv = 0; p_arv = 0; p_br = 0; p_rr = 0;
        end else begin
            if (p_awv && m_awready) begin aw_got = 1; aw_a = p_awaddr; aw_hs++; end
            if (p_wv && m_wready) begin w_got = 1; w_d = p_wdata; w_s = p_wstrb; w_hs++; end
            if (p_br && m_bvalid) begin m_bvalid = 0; b_hs++; end
            if (p_arv && m_arready) begin ar_got = 1; ar_a = p_araddr; ar_hs++; end
            if (p_rr && m_rvalid) begin m_rvalid = 0; r_hs++; end
            if (aw_got && w_got && !m_bvalid && !b_block) begin
                for (int b = 0; b < 4; b++)
                    if (w_s[b]) mem[aw_a[9:2]][8*b +: 8] = w_d[8*b +: 8];
                m_bvalid = 1; m_bresp = bresp_val; aw_got = 0; w_got = 0;
            end
            if (ar_got && !m_rvalid) begin
                m_rvalid = 1; m_rdata = mem[ar_a[9:2]]; m_rresp = rresp_val; ar_got = 0;
            end
            if (m_wvalid && !p_wv) w_wait = w_delay;
            else if (m_wvalid && w_wait > 0) w_wait--;
            m_awready = m_awvalid && !aw_got;
            m_wready  = m_wvalid && !w_got && (w_wait == 0);
            m_arready = m_arvalid && !ar_got && !ar_block;
            p_awv = m_awvalid; p_wv = m_wvalid; p_arv = m_arvalid;
            p_br = m_bready; p_rr = m_rready;
            p_awaddr = m_awaddr; p_wdata = m_wdata; p_wstrb = m_wstrb; p_araddr = m_araddr;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int n = 0;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 50) begin @(negedge clk_main_a0); n++; end
        chk("cmd_accept", {63'd0, cmd_ready}, 64'd1);
        @(negedge clk_main_a0);
        cmd_valid = 0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk_main_a0); n++; end
        chk("rsp_seen", {63'd0, rsp_valid}, 64'd1);
    endtask

    task automatic ack_rsp();
        rsp_ready = 1;
        @(negedge clk_main_a0);
        rsp_ready = 0;
    endtask

    logic [63:0] snap;
    int          n;

    initial begin
        rst_main = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        cmd_wstrb = 0; rsp_ready = 0;
        repeat (3) @(negedge clk_main_a0);
        chk("rst_outputs", {58'd0, cmd_ready, rsp_valid, m_awvalid, m_wvalid, m_arvalid,
                            m_bready | m_rready}, 64'd0);
        chk("rst_err_cnt", {48'd0, err_cnt}, 64'd0);
        chk("rst_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
        rst_main = 0;
        @(negedge clk_main_a0);
        chk("cmd_ready_post_rst", {63'd0, cmd_ready}, 64'd1);

        // zero-wait write: AW/W at T+1, bready at T+2, rsp_valid at T+3
        send_cmd(1, 32'h0000_0500, 32'hCAFE_F00D, 4'hF);
        chk("wr_aw_w_valid", {62'd0, m_awvalid, m_wvalid}, 64'd3);
        chk("wr_awaddr", {32'd0, m_awaddr}, 64'h500);
        chk("wr_wdata", {32'd0, m_wdata}, 64'hCAFE_F00D);
        @(negedge clk_main_a0);
        chk("wr_bready_t2", {62'd0, m_bready, rsp_valid}, 64'd2);
        @(negedge clk_main_a0);
        chk("wr_rsp_t3", {29'd0, rsp_valid, rsp_write, rsp_resp, rsp_timeout, rsp_rdata},
            {29'd0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0});
        ack_rsp();
        chk("b2b_cmd_ready", {62'd0, cmd_ready, rsp_valid}, 64'd2);

        // read back through the register model
        send_cmd(0, 32'h0000_0500, 32'h0, 4'h0);
        chk("rd_arvalid", {31'd0, m_arvalid, m_araddr}, {31'd0, 1'b1, 32'h500});
        wait_rsp();
        chk("rd_rsp", {29'd0, rsp_valid, rsp_write, rsp_resp, rsp_timeout, rsp_rdata},
            {29'd0, 1'b1, 1'b0, 2'b00, 1'b0, 32'hCAFE_F00D});
        ack_rsp();

        // W accepted 4 cycles after AW; partial strobe
        w_delay = 4;
        send_cmd(1, 32'h0000_0504, 32'h1234_5678, 4'h3);
        chk("dw_both_valid", {62'd0, m_awvalid, m_wvalid}, 64'd3);
        @(negedge clk_main_a0);
        chk("dw_aw_dropped", {62'd0, m_awvalid, m_wvalid}, 64'd1);
        repeat (2) @(negedge clk_main_a0);
        chk("dw_w_held", {61'd0, m_awvalid, m_wvalid, m_bready}, 64'd2);
        chk("dw_wdata_stable", {32'd0, m_wdata}, 64'h1234_5678);
        wait_rsp();
        chk("dw_rsp", {60'd0, rsp_write, rsp_resp, rsp_timeout}, 64'h8);
        ack_rsp();
        w_delay = 0;
        @(negedge clk_main_a0);
        chk("dw_single_rsp", {63'd0, rsp_valid}, 64'd0);
        chk("hs_counts", {32'd0, aw_hs[7:0], w_hs[7:0], b_hs[7:0], ar_hs[7:0]},
            64'h0202_0201);
        send_cmd(0, 32'h0000_0504, 32'h0, 4'h0);
        wait_rsp();
        chk("strobe_readback", {32'd0, rsp_rdata}, 64'h0000_5678);
        ack_rsp();

        // error responses: two SLVERR reads, one DECERR write
        rresp_val = 2'b10;
        send_cmd(0, 32'h0000_0500, 32'h0, 4'h0);
        wait_rsp();
        chk("err_rd1", {46'd0, rsp_resp, err_cnt}, {46'd0, 2'b10, 16'd1});
        ack_rsp();
        send_cmd(0, 32'h0000_0500, 32'h0, 4'h0);
        wait_rsp();
        snap = {27'd0, rsp_valid, rsp_write, rsp_resp, rsp_timeout, rsp_rdata};
        chk("err_rd2_fields", snap, {27'd0, 1'b1, 1'b0, 2'b10, 1'b0, 32'hCAFE_F00D});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_main_a0);
            chk("rsp_stable", {27'd0, rsp_valid, rsp_write, rsp_resp, rsp_timeout, rsp_rdata},
                snap);
        end
        chk("err_cnt_2", {48'd0, err_cnt}, 64'd2);
        ack_rsp();
        rresp_val = 2'b00;
        bresp_val = 2'b11;
        send_cmd(1, 32'h0000_0508, 32'h0BAD_0BAD, 4'hF);
        wait_rsp();
        chk("err_wr", {45'd0, rsp_write, rsp_resp, err_cnt}, {45'd0, 1'b1, 2'b11, 16'd3});
        ack_rsp();
        bresp_val = 2'b00;

        // asynchronous reset while waiting in WR_RESP
        b_block = 1;
        send_cmd(1, 32'h0000_050C, 32'h5555_AAAA, 4'hF);
        @(negedge clk_main_a0);
        chk("in_wr_resp", {60'd0, dbg_state, m_bready}, {60'd0, ST_WR_RESP, 1'b1});
        #2 rst_main = 1;
        #1;
        chk("async_rst_drop", {57'd0, cmd_ready, rsp_valid, m_awvalid, m_wvalid, m_arvalid,
                               m_bready, m_rready}, 64'd0);
        chk("async_rst_state", {45'd0, dbg_state, err_cnt}, {45'd0, ST_IDLE, 16'd0});
        @(negedge clk_main_a0);
        #1 rst_main = 0; b_block = 0;
        @(negedge clk_main_a0);
        chk("rst_release_ready", {63'd0, cmd_ready}, 64'd1);
        n = 0;
        repeat (4) begin @(negedge clk_main_a0); n += int'(rsp_valid); end
        chk("no_rsp_after_rst", n, 64'd0);

`ifdef AXIL_MST_TIMEOUT_EN
        // slave never accepts AR: abort after 16 cycles of m_arvalid
        ar_block = 1;
        send_cmd(0, 32'h0000_0510, 32'h0, 4'h0);
        n = 0;
        while (m_arvalid && n < 40) begin n++; @(negedge clk_main_a0); end
        chk("to_arvalid_cycles", n, 64'd16);
        chk("to_rsp", {28'd0, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata},
            {28'd0, 1'b1, 1'b1, 2'b10, 32'hDEAD_DEAD});
        chk("to_err_cnt", {46'd0, m_arvalid, m_rready, err_cnt}, 64'd1);
        ack_rsp();
        ar_block = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
